// File: rtl/mspe_src_arbiter.sv
// Round-robin packet arbiter: drains per-core source FIFOs onto one 512-bit stream.
// Whole header-framed packets only; registered output stage with valid/ready.
module mspe_src_arbiter #(
   parameter  int CORES = 4,
   localparam int CW    = (CORES > 1) ? $clog2(CORES) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [CORES-1:0]     enable,
   input  logic [CORES*512-1:0] fifo_q,
   input  logic [CORES*32-1:0]  fifo_count,
   output logic [CORES-1:0]     fifo_re,
   output logic [511:0]         src_data,
   output logic                 src_valid,
   output logic                 src_sop,
   output logic                 src_eop,
   input  logic                 src_ready,
   output logic                 busy,
   output logic [CW-1:0]        grant,
   output logic [31:0]          pkt_count,
   output logic [15:0]          err_count
);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_ptr;
   logic [CW-1:0] r_grant;
   logic [15:0]   r_words_left;
   logic          r_sop_pend;
   logic [511:0]  r_src_data;
   logic          r_src_valid;
   logic          r_src_sop;
   logic          r_src_eop;
   logic [31:0]   r_pkt_count;
   logic [15:0]   r_err_count;

   logic [15:0]   w_len [CORES];
   logic [31:0]   w_cnt [CORES];
   logic          w_hit;
   logic          w_hit_zero;
   logic [CW-1:0] w_hit_idx;
   logic [15:0]   w_hit_len;
   logic          w_start;
   logic          w_discard;
   logic          w_pop;
   logic          w_accept;
   logic          w_last;

   function automatic logic [CW-1:0] f_next(input logic [CW-1:0] i);
      if (int'(i) == CORES - 1) return '0;
      return i + 1'b1;
   endfunction

   always_comb begin
      for (int i = 0; i < CORES; i++) begin
         w_len[i] = fifo_q[i*512 +: 16];
         w_cnt[i] = fifo_count[i*32 +: 32];
      end
   end

   // Scan from the highest offset down so the core nearest ptr wins.
   always_comb begin
      int j;
      j          = 0;
      w_hit      = 1'b0;
      w_hit_zero = 1'b0;
      w_hit_idx  = '0;
      w_hit_len  = '0;
      for (int k = CORES - 1; k >= 0; k--) begin
         j = int'(r_ptr) + k;
         if (j >= CORES) j = j - CORES;
         if (enable[j] && (w_cnt[j] != 32'd0) &&
             ((w_len[j] == 16'd0) ||
              (w_cnt[j] >= {16'h0, w_len[j]}))) begin
            w_hit      = 1'b1;
            w_hit_zero = (w_len[j] == 16'd0);
            w_hit_idx  = CW'(j);
            w_hit_len  = w_len[j];
         end
      end
   end

   assign w_start   = (r_state == IDLE) && w_hit && !w_hit_zero;
   assign w_discard = (r_state == IDLE) && w_hit && w_hit_zero;
   assign w_pop     = (r_state == STREAM) && (r_words_left != 16'd0) &&
                      (!r_src_valid || src_ready);
   assign w_accept  = r_src_valid && src_ready;
   assign w_last    = (r_state == STREAM) && w_accept && r_src_eop;

   always_comb begin
      fifo_re = '0;
      if (w_discard) fifo_re[w_hit_idx] = 1'b1;
      if (w_pop)     fifo_re[r_grant]   = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:   if (w_start) w_state_nxt = STREAM;
         STREAM: if (w_last)  w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr        <= '0;
         r_grant      <= '0;
         r_words_left <= '0;
         r_sop_pend   <= 1'b0;
         r_src_data   <= '0;
         r_src_valid  <= 1'b0;
         r_src_sop    <= 1'b0;
         r_src_eop    <= 1'b0;
         r_pkt_count  <= '0;
         r_err_count  <= '0;
      end else begin
         if (w_start) begin
            r_grant      <= w_hit_idx;
            r_words_left <= w_hit_len;
            r_sop_pend   <= 1'b1;
         end
         if (w_discard) begin
            r_ptr <= f_next(w_hit_idx);
            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
         end
         if (w_pop) begin
            r_src_data   <= fifo_q[int'(r_grant)*512 +: 512];
            r_src_valid  <= 1'b1;
            r_src_sop    <= r_sop_pend;
            r_src_eop    <= (r_words_left == 16'd1);
            r_sop_pend   <= 1'b0;
            r_words_left <= r_words_left - 16'd1;
         end else if (w_accept) begin
            r_src_valid <= 1'b0;
         end
         if (w_last) begin
            r_pkt_count <= r_pkt_count + 32'd1;
            r_ptr       <= f_next(r_grant);
         end
      end
   end

   assign src_data  = r_src_data;
   assign src_valid = r_src_valid;
   assign src_sop   = r_src_sop;
   assign src_eop   = r_src_eop;
   assign busy      = (r_state != IDLE) || r_src_valid;
   assign grant     = r_grant;
   assign pkt_count = r_pkt_count;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_mspe_src_arbiter.sv
// Bench for mspe_src_arbiter: queue-based FIFO models feeding the DUT and a
// packet-level round-robin reference that predicts the output beat stream.
module tb_mspe_src_arbiter;

   localparam int CORES = 4;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b1;
   logic [CORES-1:0]     enable = '1;
   logic [CORES*512-1:0] fifo_q = '0;
   logic [CORES*32-1:0]  fifo_count = '0;
   logic [CORES-1:0]     fifo_re;
   logic [511:0]         src_data;
   logic                 src_valid;
   logic                 src_sop;
   logic                 src_eop;
   logic                 src_ready = 1'b1;
   logic                 busy;
   logic [1:0]           grant;
   logic [31:0]          pkt_count;
   logic [15:0]          err_count;

   always #5 clk = ~clk;

   mspe_src_arbiter #(.CORES(CORES)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .fifo_q     (fifo_q),
      .fifo_count (fifo_count),
      .fifo_re    (fifo_re),
      .src_data   (src_data),
      .src_valid  (src_valid),
      .src_sop    (src_sop),
      .src_eop    (src_eop),
      .src_ready  (src_ready),
      .busy       (busy),
      .grant      (grant),
      .pkt_count  (pkt_count),
      .err_count  (err_count)
   );

   typedef struct {
      logic [511:0] d;
      logic         s;
      logic         e;
   } beat_t;

   logic [511:0] fq [CORES][$];
   logic [511:0] mq [CORES][$];
   beat_t        exp_q [$];
   int           pop_cyc [$];
   int           mptr, exp_pkt, exp_err;
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   logic         prev_stall = 1'b0;
   logic [511:0] prev_d;
   logic         prev_s, prev_e;

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic void refresh();
      for (int i = 0; i < CORES; i++) begin
         fifo_count[i*32 +: 32] = fq[i].size();
         fifo_q[i*512 +: 512]   = (fq[i].size() != 0) ? fq[i][0] : '0;
      end
   endfunction

   function automatic bit sizes_match();
      bit ok = 1'b1;
      for (int i = 0; i < CORES; i++)
         if (fq[i].size() != mq[i].size()) ok = 1'b0;
      return ok;
   endfunction

   function automatic void clear_model();
      for (int i = 0; i < CORES; i++) begin
         fq[i].delete();
         mq[i].delete();
      end
      exp_q.delete();
      mptr       = 0;
      exp_pkt    = 0;
      exp_err    = 0;
      prev_stall = 1'b0;
   endfunction

   function automatic void push_word(input int core, input logic [511:0] w);
      fq[core].push_back(w);
      mq[core].push_back(w);
      refresh();
   endfunction

   function automatic void load_pkt(input int core, input int len);
      logic [511:0] h;
      h = rnd512();
      h[15:0] = 16'(len);
      push_word(core, h);
      for (int w = 1; w < len; w++) push_word(core, rnd512());
   endfunction

   // Packet-level reference: pick the first core from the pointer holding
   // either a zero-length header (discard) or a complete packet (send).
   function automatic void model_drain();
      bit found;
      int len;
      do begin
         found = 1'b0;
         for (int k = 0; k < CORES; k++) begin
            int i;
            i = (mptr + k) % CORES;
            if (!found && enable[i] && mq[i].size() != 0) begin
               len = int'(mq[i][0][15:0]);
               if (len == 0) begin
                  void'(mq[i].pop_front());
                  if (exp_err < 65535) exp_err++;
                  mptr  = (i + 1) % CORES;
                  found = 1'b1;
               end else if (mq[i].size() >= len) begin
                  for (int w = 0; w < len; w++) begin
                     beat_t b;
                     b.d = mq[i].pop_front();
                     b.s = (w == 0);
                     b.e = (w == len - 1);
                     exp_q.push_back(b);
                  end
                  exp_pkt++;
                  mptr  = (i + 1) % CORES;
                  found = 1'b1;
               end
            end
         end
      end while (found);
   endfunction

   task automatic tick();
      logic             v, r, s, e;
      logic [511:0]     d;
      logic [CORES-1:0] re;
      beat_t            b;
      @(negedge clk);
      v  = src_valid;
      r  = src_ready;
      s  = src_sop;
      e  = src_eop;
      d  = src_data;
      re = fifo_re;
      @(posedge clk);
      #1;
      cyc++;
      chk("re_onehot0", 512'($onehot0(re)), 512'(1));
      for (int i = 0; i < CORES; i++) begin
         if (re[i]) begin
            pop_cyc.push_back(cyc);
            chk("re_nonempty", 512'(fq[i].size() != 0), 512'(1));
            if (fq[i].size() != 0) void'(fq[i].pop_front());
         end
      end
      if (v && !r) chk("stall_re", 512'(re), 512'(0));
      if (prev_stall) begin
         chk("hold_valid", 512'(v), 512'(1));
         chk("hold_data", d, prev_d);
         chk("hold_sop", 512'(s), 512'(prev_s));
         chk("hold_eop", 512'(e), 512'(prev_e));
      end
      prev_stall = v && !r;
      prev_d     = d;
      prev_s     = s;
      prev_e     = e;
      if (v && r) begin
         chk("beat_expected", 512'(exp_q.size() != 0), 512'(1));
         if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk("beat_data", d, b.d);
            chk("beat_sop", 512'(s), 512'(b.s));
            chk("beat_eop", 512'(e), 512'(b.e));
         end
      end
      refresh();
   endtask

   task automatic run(input int mode, input int budget, input string tag);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && !busy && sizes_match()) && n < budget) begin
         case (mode)
            0:       src_ready = 1'b1;
            1:       src_ready = (n % 2 == 0);
            default: src_ready = ($urandom_range(0, 3) != 0);
         endcase
         tick();
         n++;
      end
      src_ready = 1'b1;
      chk({tag, "_done"}, 512'(n < budget), 512'(1));
      chk({tag, "_pkt"}, 512'(pkt_count), 512'(exp_pkt));
      chk({tag, "_err"}, 512'(err_count), 512'(exp_err));
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      clear_model();
      refresh();
      #1;
      chk({tag, "_valid"}, 512'(src_valid), 512'(0));
      chk({tag, "_sop"}, 512'(src_sop), 512'(0));
      chk({tag, "_eop"}, 512'(src_eop), 512'(0));
      chk({tag, "_data"}, src_data, 512'(0));
      chk({tag, "_busy"}, 512'(busy), 512'(0));
      chk({tag, "_grant"}, 512'(grant), 512'(0));
      chk({tag, "_pkt"}, 512'(pkt_count), 512'(0));
      chk({tag, "_err"}, 512'(err_count), 512'(0));
      chk({tag, "_re"}, 512'(fifo_re), 512'(0));
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      int span;
      int n;
      enable    = 4'hF;
      src_ready = 1'b1;
      do_reset("rst0");

      // 1: single 3-word packet on core 2, latency and contiguous pops
      load_pkt(2, 3);
      model_drain();
      pop_cyc.delete();
      tick();
      chk("t1_grant_t", 512'(grant), 512'(2));
      chk("t1_re_t1", 512'(fifo_re), 512'(4'b0100));
      chk("t1_novalid_t1", 512'(src_valid), 512'(0));
      tick();
      chk("t1_valid_t2", 512'(src_valid), 512'(1));
      chk("t1_sop_t2", 512'(src_sop), 512'(1));
      run(0, 50, "t1");
      span = (pop_cyc.size() == 3) ? pop_cyc[2] - pop_cyc[0] : -1;
      chk("t1_pops", 512'(pop_cyc.size()), 512'(3));
      chk("t1_contig", 512'(span), 512'(2));
      chk("t1_grant", 512'(grant), 512'(2));

      // 2: round-robin order 0,1,3 then wrap back to core 0
      do_reset("rst2");
      load_pkt(0, 2);
      load_pkt(1, 2);
      load_pkt(3, 2);
      model_drain();
      run(0, 100, "t2a");
      load_pkt(0, 2);
      load_pkt(3, 2);
      model_drain();
      run(0, 100, "t2b");
      chk("t2_grant", 512'(grant), 512'(3));

      // 3: alternating backpressure, enable dropped mid-packet
      load_pkt(2, 4);
      model_drain();
      tick();
      enable = 4'h0;
      run(1, 100, "t3");
      enable = 4'hF;

      // 4: incomplete packet must not start
      push_word(1, {496'h0, 16'd5});
      void'(mq[1].size());
      push_word(1, rnd512());
      push_word(1, rnd512());
      model_drain();
      repeat (20) tick();
      chk("t4_idle", 512'(busy), 512'(0));
      chk("t4_untouched", 512'(fq[1].size()), 512'(3));
      push_word(1, rnd512());
      push_word(1, rnd512());
      model_drain();
      run(0, 100, "t4");
      chk("t4_grant", 512'(grant), 512'(1));

      // 6: reset in the middle of a 6-word packet
      load_pkt(3, 6);
      model_drain();
      n = 0;
      while (!(exp_q.size() == 4 && src_valid) && n < 20) begin
         tick();
         n++;
      end
      chk("t6_reach", 512'(exp_q.size() == 4 && src_valid), 512'(1));
      do_reset("t6_rst");
      load_pkt(3, 2);
      load_pkt(1, 2);
      model_drain();
      run(0, 100, "t6");

      // 5: zero-length header discarded, pointer advances past it
      load_pkt(1, 0);
      model_drain();
      pop_cyc.delete();
      run(0, 50, "t5");
      chk("t5_pulses", 512'(pop_cyc.size()), 512'(1));
      chk("t5_err", 512'(err_count), 512'(1));
      load_pkt(0, 2);
      load_pkt(2, 2);
      model_drain();
      run(0, 100, "t5b");

      // randomized rounds: mixed lengths, masks and backpressure
      for (int rnd = 0; rnd < 12; rnd++) begin
         for (int i = 0; i < CORES; i++)
            if ($urandom_range(0, 1) == 1)
               repeat ($urandom_range(1, 2)) load_pkt(i, $urandom_range(0, 6));
         enable = 4'($urandom_range(1, 15));
         model_drain();
         run(2, 3000, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
